// File: rtl/iq_player_pkg.sv
// Shared types for the IQ pattern player.
// Holds the FSM state encoding and a channel slice helper.
package iq_player_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // LSB of channel ch inside a packed bus of w-bit lanes.
    function automatic int unsigned ch_lsb(
        input int unsigned ch,
        input int unsigned w
    );
        return ch * w;
    endfunction

endpackage

// File: rtl/iq_pattern_ram.sv
// One write / one read synchronous pattern RAM.
// Ports: clk, write (i_we/i_waddr/i_wdata), read (i_re/i_raddr), o_rdata.
module iq_pattern_ram
    import iq_player_pkg::*;
#(
    parameter  int DEPTH  = 1024,
    parameter  int WIDTH  = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Both accesses use the pre-edge array, so a same-address
    // read-during-write returns the old word.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            rdata_q <= mem_q[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/iq_pattern_player.sv
// Multi-channel IQ pattern playback source with programmable rate.
// Ports: host RAM write, start/stop/loop/len/div control, o_I/o_Q/flags.
module iq_pattern_player
    import iq_player_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int NUM_CH = 2,
    parameter  int DEPTH  = 1024,
    parameter  int DIV_W  = 16,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     i_rx_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_en,
    input  logic [CH_W-1:0]          i_wr_ch,
    input  logic [ADDR_W-1:0]        i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_I,
    input  logic [DATA_W-1:0]        i_wr_Q,
    input  logic                     i_start,
    input  logic                     i_stop,
    input  logic                     i_loop,
    input  logic [ADDR_W:0]          i_len,
    input  logic [DIV_W-1:0]         i_div,
    output logic [NUM_CH*DATA_W-1:0] o_I,
    output logic [NUM_CH*DATA_W-1:0] o_Q,
    output logic                     o_valid,
    output logic                     o_busy,
    output logic                     o_wrap,
    output logic                     o_done
);

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        idx_q, idx_d;
    logic [DIV_W-1:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]        len_m1_q, len_m1_d;
    logic [DIV_W-1:0]         div_m1_q, div_m1_d;
    logic                     loop_q, loop_d;
    logic                     valid_q, valid_d;
    logic                     wrap_q, wrap_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;
    logic [NUM_CH*DATA_W-1:0] i_q, i_d;
    logic [NUM_CH*DATA_W-1:0] q_q, q_d;

    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic [2*DATA_W-1:0]      rd_data [NUM_CH];

    logic [ADDR_W-1:0]        len_m1;
    logic [DIV_W-1:0]         div_m1;
    logic                     last;
    logic [ADDR_W-1:0]        nxt_idx;

    // Over-long requests clip to a full RAM; div 0 runs as div 1.
    assign len_m1  = (i_len > LEN_MAX) ? '1
                   : i_len[ADDR_W-1:0] - 1'b1;
    assign div_m1  = (i_div == '0) ? '0 : i_div - 1'b1;
    assign last    = (idx_q == len_m1_q);
    assign nxt_idx = last ? '0 : idx_q + 1'b1;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ram
        iq_pattern_ram #(
            .DEPTH (DEPTH),
            .WIDTH (2*DATA_W)
        ) u_ram (
            .clk     (i_rx_clk),
            .i_we    (i_wr_en && (i_wr_ch == CH_W'(g))),
            .i_waddr (i_wr_addr),
            .i_wdata ({i_wr_I, i_wr_Q}),
            .i_re    (rd_en),
            .i_raddr (rd_addr),
            .o_rdata (rd_data[g])
        );
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        len_m1_d = len_m1_q;
        div_m1_d = div_m1_q;
        loop_d   = loop_q;
        valid_d  = 1'b0;
        wrap_d   = 1'b0;
        done_d   = 1'b0;
        i_d      = i_q;
        q_d      = q_q;
        rd_en    = 1'b0;
        rd_addr  = idx_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_start && !i_stop && (i_len != '0)) begin
                    state_d  = ST_PRIME;
                    len_m1_d = len_m1;
                    div_m1_d = div_m1;
                    loop_d   = i_loop;
                end
            end
            ST_PRIME: begin
                if (i_stop) begin
                    state_d = ST_IDLE;
                end else begin
                    rd_en   = 1'b1;
                    rd_addr = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_stop) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    // The next sample is fetched on the strobe
                    // itself so div=1 can emit every clock.
                    valid_d = 1'b1;
                    rd_en   = 1'b1;
                    rd_addr = nxt_idx;
                    idx_d   = nxt_idx;
                    cnt_d   = div_m1_q;
                    if (last && loop_q) begin
                        wrap_d = 1'b1;
                    end else if (last) begin
                        done_d  = 1'b1;
                        rd_en   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (valid_d) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                i_d[ch_lsb(k, DATA_W) +: DATA_W] =
                    rd_data[k][2*DATA_W-1:DATA_W];
                q_d[ch_lsb(k, DATA_W) +: DATA_W] =
                    rd_data[k][DATA_W-1:0];
            end
        end

        // Busy stays up through the done strobe, drops after it.
        busy_d = (state_d != ST_IDLE) || done_d;
    end

    always_ff @(posedge i_rx_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            len_m1_q <= '0;
            div_m1_q <= '0;
            loop_q   <= 1'b0;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            i_q      <= '0;
            q_q      <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            len_m1_q <= len_m1_d;
            div_m1_q <= div_m1_d;
            loop_q   <= loop_d;
            valid_q  <= valid_d;
            wrap_q   <= wrap_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            i_q      <= i_d;
            q_q      <= q_d;
        end
    end

    assign o_I     = i_q;
    assign o_Q     = q_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_wrap  = wrap_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_iq_pattern_player.sv
// Scoreboard bench for iq_pattern_player.
// Directed runs push expected strobes; a monitor pops and compares.
module tb_iq_pattern_player;

    localparam int DATA_W = 16;
    localparam int NUM_CH = 2;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;
    localparam int DIV_W  = 16;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     i_wr_en = 1'b0;
    logic [0:0]               i_wr_ch = '0;
    logic [ADDR_W-1:0]        i_wr_addr = '0;
    logic [DATA_W-1:0]        i_wr_I = '0;
    logic [DATA_W-1:0]        i_wr_Q = '0;
    logic                     i_start = 1'b0;
    logic                     i_stop = 1'b0;
    logic                     i_loop = 1'b0;
    logic [ADDR_W:0]          i_len = '0;
    logic [DIV_W-1:0]         i_div = '0;
    logic [NUM_CH*DATA_W-1:0] o_I;
    logic [NUM_CH*DATA_W-1:0] o_Q;
    logic                     o_valid;
    logic                     o_busy;
    logic                     o_wrap;
    logic                     o_done;

    iq_pattern_player #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH),
        .DIV_W  (DIV_W)
    ) dut (
        .i_rx_clk  (clk),
        .i_rst_n   (rst_n),
        .i_wr_en   (i_wr_en),
        .i_wr_ch   (i_wr_ch),
        .i_wr_addr (i_wr_addr),
        .i_wr_I    (i_wr_I),
        .i_wr_Q    (i_wr_Q),
        .i_start   (i_start),
        .i_stop    (i_stop),
        .i_loop    (i_loop),
        .i_len     (i_len),
        .i_div     (i_div),
        .o_I       (o_I),
        .o_Q       (o_Q),
        .o_valid   (o_valid),
        .o_busy    (o_busy),
        .o_wrap    (o_wrap),
        .o_done    (o_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          cyc;
        logic [31:0] ei;
        logic [31:0] eq;
        logic        w;
        logic        d;
    } exp_t;

    exp_t sb [$];

    logic [15:0] mi [NUM_CH][DEPTH];
    logic [15:0] mq [NUM_CH][DEPTH];

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wr(input int ch, input int addr,
                      input logic [15:0] vi,
                      input logic [15:0] vq);
        i_wr_en   = 1'b1;
        i_wr_ch   = 1'(ch);
        i_wr_addr = 10'(addr);
        i_wr_I    = vi;
        i_wr_Q    = vq;
        @(negedge clk);
        i_wr_en   = 1'b0;
        mi[ch][addr] = vi;
        mq[ch][addr] = vq;
    endtask

    // Returns at the negedge after the start edge; base is the
    // cycle count seen after that edge minus nothing extra.
    task automatic start(input int len, input int dv,
                         input bit lp, output int base);
        i_len   = 11'(len);
        i_div   = 16'(dv);
        i_loop  = lp;
        i_start = 1'b1;
        base    = cyc + 1;
        @(negedge clk);
        i_start = 1'b0;
        i_len   = 11'd1;
        i_div   = 16'd7;
        i_loop  = ~lp;
    endtask

    task automatic push_run(input int base, input int len,
                            input int dv, input bit lp,
                            input int n);
        exp_t e;
        int   idx;
        for (int k = 0; k < n; k++) begin
            idx   = k % len;
            e.cyc = base + 2 + k * dv;
            e.ei  = {mi[1][idx], mi[0][idx]};
            e.eq  = {mq[1][idx], mq[0][idx]};
            e.w   = lp && (idx == len - 1);
            e.d   = !lp && (idx == len - 1);
            sb.push_back(e);
        end
    endtask

    task automatic drain(input string nm, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        chk({nm, "_drain"}, 64'(sb.size()), 64'd0);
        sb.delete();
        repeat (3) @(negedge clk);
    endtask

    bit   prev_done = 1'b0;
    exp_t me;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (prev_done) chk("busy_after_done", 64'(o_busy), 64'd0);
            prev_done = o_valid && o_done;
            if (o_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got strobe at cycle %0d, want none", cyc);
                end else begin
                    me = sb.pop_front();
                    chk("strobe_cycle", 64'(cyc), 64'(me.cyc));
                    chk("o_I", 64'(o_I), 64'(me.ei));
                    chk("o_Q", 64'(o_Q), 64'(me.eq));
                    chk("o_wrap", 64'(o_wrap), 64'(me.w));
                    chk("o_done", 64'(o_done), 64'(me.d));
                    chk("busy_strobe", 64'(o_busy), 64'd1);
                end
            end else begin
                chk("flags_quiet", 64'({o_wrap, o_done}), 64'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1ms, want finish");
        $fatal(1);
    end

    int base;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_o_I", 64'(o_I), 64'd0);
        chk("rst_o_Q", 64'(o_Q), 64'd0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_wrap", 64'(o_wrap), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int a = 0; a < DEPTH; a++) begin
            wr(0, a, 16'(a), ~16'(a));
            wr(1, a, 16'(100 + a), 16'(3 * a));
        end

        // T1: one-shot, div 4
        start(8, 4, 1'b0, base);
        chk("t1_busy", 64'(o_busy), 64'd1);
        push_run(base, 8, 4, 1'b0, 8);
        drain("t1", 100);

        // T2: loop, div 1, stop after 12 strobes
        start(4, 1, 1'b1, base);
        push_run(base, 4, 1, 1'b1, 12);
        repeat (13) @(negedge clk);
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        chk("t2_busy_stop", 64'(o_busy), 64'd0);
        chk("t2_left", 64'(sb.size()), 64'd0);
        repeat (5) @(negedge clk);

        // T3: div 0 behaves as div 1
        start(3, 0, 1'b0, base);
        push_run(base, 3, 1, 1'b0, 3);
        drain("t3", 20);

        // T4: len 0 ignored
        start(0, 3, 1'b0, base);
        chk("t4_busy", 64'(o_busy), 64'd0);
        repeat (10) @(negedge clk);
        chk("t4_busy_late", 64'(o_busy), 64'd0);

        // T5: len clipped to DEPTH
        start(2000, 1, 1'b0, base);
        push_run(base, DEPTH, 1, 1'b0, DEPTH);
        drain("t5", 1100);

        // T6: stop during strobe 3, then start+stop
        start(6, 5, 1'b0, base);
        push_run(base, 6, 5, 1'b0, 3);
        repeat (12) @(negedge clk);
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        chk("t6_busy", 64'(o_busy), 64'd0);
        chk("t6_hold_I", 64'(o_I), 64'({mi[1][2], mi[0][2]}));
        repeat (10) @(negedge clk);
        chk("t6_left", 64'(sb.size()), 64'd0);
        chk("t6_hold_late", 64'(o_I), 64'({mi[1][2], mi[0][2]}));
        i_len   = 11'd4;
        i_div   = 16'd1;
        i_start = 1'b1;
        i_stop  = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_stop  = 1'b0;
        chk("t6_ss_busy", 64'(o_busy), 64'd0);
        repeat (10) @(negedge clk);
        chk("t6_ss_late", 64'(o_busy), 64'd0);

        // T7: reset mid-run, then replay
        start(8, 2, 1'b1, base);
        push_run(base, 8, 2, 1'b1, 3);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t7_o_I", 64'(o_I), 64'd0);
        chk("t7_o_Q", 64'(o_Q), 64'd0);
        chk("t7_valid", 64'(o_valid), 64'd0);
        chk("t7_busy", 64'(o_busy), 64'd0);
        chk("t7_wrap", 64'(o_wrap), 64'd0);
        chk("t7_done", 64'(o_done), 64'd0);
        chk("t7_left", 64'(sb.size()), 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start(4, 1, 1'b0, base);
        push_run(base, 4, 1, 1'b0, 4);
        drain("t7", 20);

        // T8a: write index 5 two clocks before its read
        start(8, 8, 1'b0, base);
        mi[0][5] = 16'h5A5A;
        mq[0][5] = 16'h1234;
        push_run(base, 8, 8, 1'b0, 8);
        repeat (31) @(negedge clk);
        wr(0, 5, 16'h5A5A, 16'h1234);
        drain("t8a", 100);

        // T8b: write lands on the read edge, old data wins
        start(8, 8, 1'b0, base);
        push_run(base, 8, 8, 1'b0, 8);
        repeat (33) @(negedge clk);
        wr(0, 5, 16'hBEEF, 16'h4321);
        drain("t8b", 100);

        // T8c: the collided write did land
        start(6, 1, 1'b0, base);
        push_run(base, 6, 1, 1'b0, 6);
        drain("t8c", 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
